// File: rtl/spm_operand_sequencer.sv
// Operand sequencer for a chain of serial-parallel multipliers: holds x, streams sign-extended y
// LSB first over 2*size cycles. Define SPM_CAPTURE_EN to also capture the serial product.
module spm_operand_sequencer #(
  parameter int unsigned size = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [size-1:0]     x_in,
  input  logic [size-1:0]     y_in,
  output logic [size-1:0]     x_out,
  output logic                y_out,
  output logic                busy,
  output logic                done
`ifdef SPM_CAPTURE_EN
  ,
  input  logic                p_in,
  output logic [2*size-1:0]   product,
  output logic                prod_valid
`endif
);

  localparam int unsigned     CntW    = $clog2(2 * size) + 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(2 * size - 1);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e          state_q, state_d;
  logic [size-1:0] x_q, x_d;
  logic [size-1:0] yreg_q, yreg_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            accept;

  // in_ready is held low while rst is asserted so nothing is accepted during reset.
  assign in_ready = (state_q == StIdle) && !rst;
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    yreg_d  = yreg_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          x_d     = x_in;
          yreg_d  = y_in;
          cnt_d   = '0;
          state_d = StShift;
        end
      end
      StShift: begin
        // Arithmetic shift: after size shifts the register holds pure sign bits.
        yreg_d = {yreg_q[size-1], yreg_q[size-1:1]};
        cnt_d  = cnt_q + CntW'(1);
        if (cnt_q == LastCnt) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      x_q     <= '0;
      yreg_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      yreg_q  <= yreg_d;
      cnt_q   <= cnt_d;
    end
  end

  assign x_out = x_q;
  assign y_out = (state_q == StShift) && yreg_q[0];
  assign busy  = (state_q != StIdle);
  assign done  = (state_q == StDone);

`ifdef SPM_CAPTURE_EN
  logic [2*size-1:0] prod_q, prod_d;
  logic              pv_q, pv_d;

  always_comb begin
    prod_d = prod_q;
    pv_d   = pv_q;
    if (accept) begin
      prod_d = '0;
      pv_d   = 1'b0;
    end
    // p_in lags y_out by one cycle: sample from the second SHIFT cycle through DONE.
    if ((state_q == StShift && cnt_q != '0) || state_q == StDone) begin
      prod_d = {p_in, prod_q[2*size-1:1]};
    end
    if (state_q == StDone) begin
      pv_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prod_q <= '0;
      pv_q   <= 1'b0;
    end else begin
      prod_q <= prod_d;
      pv_q   <= pv_d;
    end
  end

  assign product    = prod_q;
  assign prod_valid = pv_q;
`endif

endmodule

// File: tb/tb_spm_operand_sequencer.sv
// Self-checking bench for spm_operand_sequencer (size=8): directed table, back-to-back,
// random pairs against an arithmetic model, and reset abort.
module tb_spm_operand_sequencer;

  localparam int unsigned Size = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [Size-1:0]   x_in, y_in, x_out;
  logic              y_out, busy, done;
`ifdef SPM_CAPTURE_EN
  logic              p_in;
  logic [2*Size-1:0] product;
  logic              prod_valid;
`endif

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int last_acc = 0;
  int prev_acc = 0;
  int tcnt   = 0;
  logic [2*Size-1:0] pval = '0;

  spm_operand_sequencer #(.size(Size)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .x_in       (x_in),
    .y_in       (y_in),
    .x_out      (x_out),
    .y_out      (y_out),
    .busy       (busy),
    .done       (done)
`ifdef SPM_CAPTURE_EN
    ,
    .p_in       (p_in),
    .product    (product),
    .prod_valid (prod_valid)
`endif
  );

  always #5 clk = ~clk;

  function automatic int sval(input logic [Size-1:0] v);
    return v[Size-1] ? int'(v) - (1 << Size) : int'(v);
  endfunction

  // Sign-extended y as a 2*size bit stream, and the full signed product.
  function automatic logic [2*Size-1:0] model_seq(input logic [Size-1:0] y);
    return (2*Size)'(sval(y));
  endfunction

  function automatic logic [2*Size-1:0] model_prod(input logic [Size-1:0] x, y);
    return (2*Size)'(sval(x) * sval(y));
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Tracks acceptances; also serves as a behavioural downstream multiplier emitting
  // product bit k during cycle T(k+2).
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      tcnt <= 0;
    end else if (in_valid && in_ready) begin
      tcnt     <= 1;
      pval     <= model_prod(x_in, y_in);
      prev_acc <= last_acc;
      last_acc <= cyc;
    end else if (tcnt != 0 && tcnt < 60) begin
      tcnt <= tcnt + 1;
    end
  end

`ifdef SPM_CAPTURE_EN
  assign p_in = (tcnt >= 2 && tcnt <= 2*Size + 1) ? pval[tcnt-2] : 1'b0;
`endif

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_reset_outputs(input string nm);
    chk({nm, "_x_out"}, x_out, 0);
    chk({nm, "_y_out"}, y_out, 0);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_done"}, done, 0);
    chk({nm, "_in_ready"}, in_ready, 0);
`ifdef SPM_CAPTURE_EN
    chk({nm, "_product"}, product, 0);
    chk({nm, "_prod_valid"}, prod_valid, 0);
`endif
  endtask

  // Called at posedge+1; returns at T18+1 (hold=1) or one idle cycle later (hold=0).
  task automatic run_txn(input logic [Size-1:0] x, input logic [Size-1:0] y,
                         input logic [2*Size-1:0] exp_seq, input bit hold, input bit chk_gap);
    int waited = 0;
    in_valid = 1'b1;
    x_in     = x;
    y_in     = y;
    while (!in_ready && waited < 40) begin
      tick();
      waited++;
    end
    if (!in_ready) begin
      chk("accept_timeout", 0, 1);
      in_valid = 1'b0;
      return;
    end
    tick();
    if (!hold) in_valid = 1'b0;
    if (chk_gap) chk("accept_gap", 64'(last_acc - prev_acc), 2*Size + 2);
    for (int k = 0; k < 2*Size; k++) begin
      chk($sformatf("y_out_bit%0d", k), y_out, exp_seq[k]);
      chk("x_out_shift", x_out, x);
      chk("busy_shift", busy, 1);
      chk("done_shift", done, 0);
      chk("in_ready_shift", in_ready, 0);
`ifdef SPM_CAPTURE_EN
      chk("prod_valid_shift", prod_valid, 0);
`endif
      x_in = Size'($urandom);
      y_in = Size'($urandom);
      tick();
    end
    chk("done_pulse", done, 1);
    chk("busy_done", busy, 1);
    chk("y_out_done", y_out, 0);
    chk("in_ready_done", in_ready, 0);
    chk("x_out_done", x_out, x);
    tick();
    chk("done_after", done, 0);
    chk("busy_idle", busy, 0);
    chk("in_ready_idle", in_ready, 1);
    chk("x_out_idle", x_out, x);
`ifdef SPM_CAPTURE_EN
    chk("prod_valid_set", prod_valid, 1);
    chk("product", product, model_prod(x, y));
`endif
    if (!hold) begin
      tick();
      chk("x_out_hold", x_out, x);
      chk("y_out_idle", y_out, 0);
`ifdef SPM_CAPTURE_EN
      chk("prod_valid_hold", prod_valid, 1);
      chk("product_hold", product, model_prod(x, y));
`endif
    end
  endtask

  typedef struct {
    logic [Size-1:0]   x;
    logic [Size-1:0]   y;
    logic [2*Size-1:0] seq;
  } vec_t;

  vec_t vecs[4];

  initial begin
    vecs[0] = '{x: 8'd3,   y: 8'd5,   seq: 16'h0005};
    vecs[1] = '{x: 8'h7F,  y: 8'hFE,  seq: 16'hFFFE};
    vecs[2] = '{x: 8'h80,  y: 8'h80,  seq: 16'hFF80};
    vecs[3] = '{x: 8'hFD,  y: 8'd7,   seq: 16'h0007};

    rst      = 1'b0;
    in_valid = 1'b0;
    x_in     = '0;
    y_in     = '0;
    #1 rst = 1'b1;
    #1 chk_reset_outputs("reset_async");
    tick();
    tick();
    #3 rst = 1'b0;
    tick();
    chk("in_ready_after_reset", in_ready, 1);
    chk("busy_after_reset", busy, 0);

`ifdef SPM_CAPTURE_EN
    // The canonical capture case: -3 * 7 = 16'hFFEB.
    run_txn(8'hFD, 8'd7, 16'h0007, 1'b0, 1'b0);
    chk("product_ffeb", product, 16'hFFEB);
`endif

    foreach (vecs[i]) run_txn(vecs[i].x, vecs[i].y, vecs[i].seq, 1'b0, 1'b0);

    // Back-to-back with in_valid held high throughout.
    for (int i = 0; i < 4; i++) begin
      logic [Size-1:0] rx, ry;
      rx = Size'($urandom);
      ry = Size'($urandom);
      run_txn(rx, ry, model_seq(ry), i < 3, i > 0);
    end

    for (int i = 0; i < 8; i++) begin
      logic [Size-1:0] rx, ry;
      rx = Size'($urandom);
      ry = Size'($urandom);
      run_txn(rx, ry, model_seq(ry), 1'b0, 1'b0);
    end

    // Abort at T9: reset mid-cycle, no done pulse, clean restart.
    in_valid = 1'b1;
    x_in     = 8'h5A;
    y_in     = 8'hC3;
    tick();
    in_valid = 1'b0;
    for (int k = 1; k < 9; k++) tick();
    chk("busy_before_abort", busy, 1);
    #3 rst = 1'b1;
    #1 chk_reset_outputs("abort");
    tick();
    chk("done_abort_1", done, 0);
    tick();
    chk("done_abort_2", done, 0);
    #3 rst = 1'b0;
    tick();
    chk("in_ready_post_abort", in_ready, 1);
    chk("done_post_abort", done, 0);
    tick();
    chk("done_post_abort_2", done, 0);
    run_txn(8'd3, 8'd5, 16'h0005, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
